difftest_uart_host: RTL

Harness-side endpoint for the SimTop difftest UART ports. It captures characters the DUT emits on `uart_out` into a buffer that the host drains with a valid/ready handshake. It answers the DUT's `uart_in` getc requests from a host-filled input queue. It is instantiated in the formal/sim top beside SimTop, in place of tying `difftest_uart_in_ch` to a constant.

---
 rtl/difftest_uart_pkg.sv | 12 +
 rtl/difftest_uart_fifo.sv | 67 ++++++
 rtl/difftest_uart_host.sv | 129 ++++++++++++
 3 files changed

// File: rtl/difftest_uart_pkg.sv
// rtl/difftest_uart_pkg.sv - shared types and constants for the difftest UART host endpoint
package difftest_uart_pkg;

  typedef logic [7:0] uart_ch_t;

  // Byte handed to a getc that finds the input queue empty
  localparam uart_ch_t EMPTY_CH_DEFAULT = 8'hFF;

  // Width of the optional saturating statistics counters
  localparam int STAT_W = 32;

endpackage

// File: rtl/difftest_uart_fifo.sv
// rtl/difftest_uart_fifo.sv - show-ahead byte FIFO with push/pop/full/empty/count
module difftest_uart_fifo
  import difftest_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  uart_ch_t                 push_ch,
  input  logic                     pop,
  output uart_ch_t                 head_ch,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  uart_ch_t          mem_q [DEPTH];
  uart_ch_t          mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en;
  logic              pop_en;

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts push+pop
  always_comb begin
    pop_en   = pop && (count_q != '0);
    push_en  = push && ((count_q != FULL_CNT) || pop_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_ch;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  // Storage, pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_ch = mem_q[rd_ptr_q];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/difftest_uart_host.sv
// rtl/difftest_uart_host.sv - SimTop UART putc capture and getc feed (stats under DIFFTEST_UART_STATS_EN)
module difftest_uart_host
  import difftest_uart_pkg::*;
#(
  parameter int       OUT_DEPTH = 16,
  parameter int       IN_DEPTH  = 16,
  parameter uart_ch_t EMPTY_CH  = EMPTY_CH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              uart_out_valid,
  input  logic [7:0]        uart_out_ch,
  input  logic              uart_in_valid,
  output logic [7:0]        uart_in_ch,
  output logic              host_out_valid,
  output logic [7:0]        host_out_ch,
  input  logic              host_out_ready,
  input  logic              host_in_valid,
  input  logic [7:0]        host_in_ch,
  output logic              host_in_ready,
  output logic              out_overflow
`ifdef DIFFTEST_UART_STATS_EN
  ,
  output logic [STAT_W-1:0] out_count,
  output logic [STAT_W-1:0] in_count,
  output logic [STAT_W-1:0] starve_count
`endif
);

  uart_ch_t                   out_head;
  logic                       out_full;
  logic                       out_empty;
  logic [$clog2(OUT_DEPTH):0] out_cnt;
  uart_ch_t                   in_head;
  logic                       in_full;
  logic                       in_empty;
  logic [$clog2(IN_DEPTH):0]  in_cnt;
  logic                       out_pop;
  logic                       in_push;
  logic                       in_pop;
  logic                       rdy_q, rdy_d;
  logic                       ovf_q, ovf_d;
  logic                       unused_cnt;

  assign unused_cnt = ^{out_cnt, in_cnt};

  difftest_uart_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .push    (uart_out_valid),
    .push_ch (uart_out_ch),
    .pop     (out_pop),
    .head_ch (out_head),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_cnt)
  );

  difftest_uart_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .push    (in_push),
    .push_ch (host_in_ch),
    .pop     (in_pop),
    .head_ch (in_head),
    .full    (in_full),
    .empty   (in_empty),
    .count   (in_cnt)
  );

  // Handshakes; rdy_q holds host_in_ready low until the first edge after reset release
  always_comb begin
    host_out_valid = !out_empty;
    host_out_ch    = out_empty ? 8'h00 : out_head;
    out_pop        = host_out_valid && host_out_ready;
    host_in_ready  = rdy_q && !in_full;
    in_push        = host_in_valid && host_in_ready;
    in_pop         = uart_in_valid && !in_empty;
    uart_in_ch     = in_empty ? EMPTY_CH : in_head;
    rdy_d          = 1'b1;
    ovf_d          = ovf_q || (uart_out_valid && out_full && !out_pop);
    out_overflow   = ovf_q;
  end

  // Ready-enable and sticky overflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef DIFFTEST_UART_STATS_EN
  logic [STAT_W-1:0] out_count_q, out_count_d;
  logic [STAT_W-1:0] in_count_q, in_count_d;
  logic [STAT_W-1:0] starve_count_q, starve_count_d;

  // Saturating event counters: captured putc, served getc, starved getc
  always_comb begin
    out_count_d    = out_count_q;
    in_count_d     = in_count_q;
    starve_count_d = starve_count_q;
    if (uart_out_valid && (out_count_q != '1)) out_count_d = out_count_q + 1'b1;
    if (in_pop && (in_count_q != '1)) in_count_d = in_count_q + 1'b1;
    if (uart_in_valid && in_empty && (starve_count_q != '1)) starve_count_d = starve_count_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_count_q    <= '0;
      in_count_q     <= '0;
      starve_count_q <= '0;
    end else begin
      out_count_q    <= out_count_d;
      in_count_q     <= in_count_d;
      starve_count_q <= starve_count_d;
    end
  end

  assign out_count    = out_count_q;
  assign in_count     = in_count_q;
  assign starve_count = starve_count_q;
`endif

endmodule
